// File: rtl/uart_tx_arbiter.sv
// Two-requester UART transmitter: round-robin grant of one byte per frame, 8N1, LSB first.
// The serial line and grant pulses are registered so downstream sees glitch-free outputs.
module uart_tx_arbiter #(
   parameter int unsigned CLKS_PER_BIT = 10416
) (
   input  logic       sys_clk,
   input  logic       reset,
   input  logic       req0,
   input  logic [7:0] data0,
   output logic       gnt0,
   input  logic       req1,
   input  logic [7:0] data1,
   output logic       gnt1,
   output logic       UART_TX,
   output logic       tx_busy
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic            last_q, last_d;
   logic            tx_q, tx_d;
   logic            gnt0_q, gnt0_d;
   logic            gnt1_q, gnt1_d;

   logic win0, win1, bit_done;

   // On a tie the requester that was not served last wins.
   assign win0     = req0 & (~req1 | last_q);
   assign win1     = req1 & (~req0 | ~last_q);
   assign bit_done = (cnt_q == CntMax);

   always_ff @(posedge sys_clk) begin
      if (reset) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         idx_q   <= '0;
         shift_q <= '0;
         last_q  <= 1'b1;
         tx_q    <= 1'b1;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         idx_q   <= idx_d;
         shift_q <= shift_d;
         last_q  <= last_d;
         tx_q    <= tx_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      last_d  = last_q;
      unique case (state_q)
         StIdle: begin
            if (win0 || win1) begin
               state_d = StStart;
               cnt_d   = '0;
               idx_d   = '0;
               shift_d = win1 ? data1 : data0;
               last_d  = win1;
            end
         end
         StStart: begin
            if (bit_done) begin
               cnt_d   = '0;
               state_d = StData;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StData: begin
            if (bit_done) begin
               cnt_d = '0;
               if (idx_q == 3'd7) begin
                  state_d = StStop;
               end else begin
                  idx_d   = idx_q + 3'd1;
                  shift_d = {1'b0, shift_q[7:1]};
               end
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         StStop: begin
            if (bit_done) begin
               cnt_d   = '0;
               state_d = StIdle;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Line level is derived from the next state so the registered output lines up with it.
   always_comb begin
      tx_d   = 1'b1;
      gnt0_d = (state_q == StIdle) && win0;
      gnt1_d = (state_q == StIdle) && win1;
      case (state_d)
         StStart: tx_d = 1'b0;
         StData:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

   assign UART_TX = tx_q;
   assign gnt0    = gnt0_q;
   assign gnt1    = gnt1_q;
   assign tx_busy = (state_q != StIdle);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: frame shape, arbitration, reset abort and default bit period.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

   localparam int unsigned Cpb    = 4;
   localparam int unsigned DefCpb = 10416;

   logic       sys_clk = 1'b0;
   logic       reset, req0, req1;
   logic [7:0] data0, data1;
   logic       gnt0, gnt1, uart_tx, tx_busy;

   logic       d_reset, d_req0, d_req1;
   logic [7:0] d_data0, d_data1;
   logic       d_gnt0, d_gnt1, d_tx, d_busy;

   int n_checks = 0;
   int n_errors = 0;

   always #5 sys_clk = ~sys_clk;

   uart_tx_arbiter #(.CLKS_PER_BIT(Cpb)) u_dut (
      .sys_clk (sys_clk),
      .reset   (reset),
      .req0    (req0),
      .data0   (data0),
      .gnt0    (gnt0),
      .req1    (req1),
      .data1   (data1),
      .gnt1    (gnt1),
      .UART_TX (uart_tx),
      .tx_busy (tx_busy)
   );

   uart_tx_arbiter u_dut_def (
      .sys_clk (sys_clk),
      .reset   (d_reset),
      .req0    (d_req0),
      .data0   (d_data0),
      .gnt0    (d_gnt0),
      .req1    (d_req1),
      .data1   (d_data1),
      .gnt1    (d_gnt1),
      .UART_TX (d_tx),
      .tx_busy (d_busy)
   );

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   // Called in an IDLE cycle with the request(s) already driven; ends in the following IDLE cycle.
   task automatic run_frame(input string tag, input logic [9:0] frame, input logic exp_g0,
                            input logic exp_g1, input bit clr, input bit mid_req0,
                            input bit scramble);
      logic [9:0] sh;
      sh = frame;
      tick();
      check_eq({tag, "/gnt0"}, 32'(gnt0), 32'(exp_g0));
      check_eq({tag, "/gnt1"}, 32'(gnt1), 32'(exp_g1));
      if (clr) begin
         if (exp_g0) req0 = 1'b0;
         if (exp_g1) req1 = 1'b0;
      end
      for (int k = 0; k < 10 * Cpb; k++) begin
         check_eq({tag, "/tx"}, 32'(uart_tx), 32'(sh[0]));
         check_eq({tag, "/busy"}, 32'(tx_busy), 32'd1);
         if (k > 0) check_eq({tag, "/gnt_mid"}, 32'({gnt0, gnt1}), 32'd0);
         if (mid_req0 && k == 8) begin
            req0  = 1'b1;
            data0 = 8'h5A;
         end
         if (scramble && k == 5) begin
            data0 = ~data0;
            data1 = ~data1;
         end
         if ((k % Cpb) == Cpb - 1) sh = sh >> 1;
         tick();
      end
      check_eq({tag, "/idle_busy"}, 32'(tx_busy), 32'd0);
      check_eq({tag, "/idle_tx"}, 32'(uart_tx), 32'd1);
      check_eq({tag, "/idle_gnt"}, 32'({gnt0, gnt1}), 32'd0);
   endtask

   initial begin
      reset   = 1'b1;
      req0    = 1'b0;
      req1    = 1'b0;
      data0   = 8'h00;
      data1   = 8'h00;
      d_reset = 1'b1;
      d_req0  = 1'b0;
      d_req1  = 1'b0;
      d_data0 = 8'h00;
      d_data1 = 8'h00;
      tick();
      tick();
      check_eq("rst/tx", 32'(uart_tx), 32'd1);
      check_eq("rst/busy", 32'(tx_busy), 32'd0);
      check_eq("rst/gnt0", 32'(gnt0), 32'd0);
      check_eq("rst/gnt1", 32'(gnt1), 32'd0);
      reset = 1'b0;

      // Single byte A5: 0,1,0,1,0,0,1,0,1,1 on the line
      req0  = 1'b1;
      data0 = 8'hA5;
      run_frame("a5", 10'b1101001010, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Both held from reset: alternate 0,1,0,1, starts 41 cycles apart
      reset = 1'b1;
      tick();
      reset = 1'b0;
      req0  = 1'b1;
      data0 = 8'h11;
      req1  = 1'b1;
      data1 = 8'h22;
      run_frame("tie1", 10'b1000100010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("tie2", 10'b1001000100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      run_frame("tie3", 10'b1000100010, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      run_frame("tie4", 10'b1001000100, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
      req0 = 1'b0;

      // req0 raised mid-frame is held off until after the IDLE cycle
      req1  = 1'b1;
      data1 = 8'h80;
      run_frame("x80", 10'b1100000000, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      run_frame("x5a", 10'b1010110100, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

      // Data changed while busy: latched byte goes out
      req0  = 1'b1;
      data0 = 8'h3C;
      run_frame("x3c", 10'b1001111000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);

      // Reset at cycle 15 of a frame aborts it
      req0  = 1'b1;
      data0 = 8'hFF;
      tick();
      check_eq("abort/gnt0", 32'(gnt0), 32'd1);
      req0 = 1'b0;
      repeat (14) tick();
      check_eq("abort/busy_pre", 32'(tx_busy), 32'd1);
      reset = 1'b1;
      tick();
      check_eq("abort/tx", 32'(uart_tx), 32'd1);
      check_eq("abort/busy", 32'(tx_busy), 32'd0);
      check_eq("abort/gnt", 32'({gnt0, gnt1}), 32'd0);
      reset = 1'b0;
      tick();
      check_eq("abort/tx2", 32'(uart_tx), 32'd1);
      check_eq("abort/busy2", 32'(tx_busy), 32'd0);
      check_eq("abort/gnt2", 32'({gnt0, gnt1}), 32'd0);

      // Reset beats a simultaneous request
      req1  = 1'b1;
      data1 = 8'h81;
      reset = 1'b1;
      tick();
      check_eq("rstprio/gnt1", 32'(gnt1), 32'd0);
      check_eq("rstprio/busy", 32'(tx_busy), 32'd0);
      reset = 1'b0;
      run_frame("x81", 10'b1100000010, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

      // Default 100 MHz / 9600 baud: bit boundaries every 10416 cycles for byte 55
      d_reset = 1'b0;
      d_req0  = 1'b1;
      d_data0 = 8'h55;
      tick();
      check_eq("def/gnt0", 32'(d_gnt0), 32'd1);
      check_eq("def/gnt1", 32'(d_gnt1), 32'd0);
      check_eq("def/busy", 32'(d_busy), 32'd1);
      check_eq("def/start", 32'(d_tx), 32'd0);
      d_req0 = 1'b0;
      repeat (DefCpb - 1) tick();
      check_eq("def/start_end", 32'(d_tx), 32'd0);
      tick();
      check_eq("def/bit0", 32'(d_tx), 32'd1);
      repeat (DefCpb - 1) tick();
      check_eq("def/bit0_end", 32'(d_tx), 32'd1);
      tick();
      check_eq("def/bit1", 32'(d_tx), 32'd0);
      d_reset = 1'b1;
      tick();
      check_eq("def/rst_busy", 32'(d_busy), 32'd0);
      check_eq("def/rst_tx", 32'(d_tx), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
